// File: rtl/csr_int_timer_ctrl.sv
// Interrupt and timer CSR block: ECFG, ESTAT.IS, TID, TCFG, TVAL and TICLR.
// It runs the constant timer FSM and the 64-bit stable counter, samples the
// hardware and IPI lines, and produces the registered has_int request.
module csr_int_timer_ctrl #(
   parameter int unsigned TIMER_W = 32,
   parameter logic [31:0] TID_RST = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_we,
   input  logic [13:0] csr_num,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_hit,
   input  logic        crmd_ie,
   input  logic [7:0]  hard_int_in,
   input  logic        ipi_int_in,
   output logic        has_int,
   output logic [63:0] stable_cnt,
   output logic [1:0]  timer_state
);

   localparam logic [13:0] CSR_ECFG  = 14'h004;
   localparam logic [13:0] CSR_ESTAT = 14'h005;
   localparam logic [13:0] CSR_TID   = 14'h040;
   localparam logic [13:0] CSR_TCFG  = 14'h041;
   localparam logic [13:0] CSR_TVAL  = 14'h042;
   localparam logic [13:0] CSR_TICLR = 14'h044;

   // LIE bit 10 does not exist; only [9:0] and [12:11] hold state.
   localparam logic [12:0] LIE_MASK = 13'h1BFF;
   localparam logic [TIMER_W-1:0] TVAL_ONE = TIMER_W'(1);

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_DONE = 2'd2
   } timer_state_e;

   timer_state_e        state_q, state_d;
   logic [12:0]         lie_q, lie_d;
   logic [12:0]         is_q, is_d;
   logic [31:0]         tid_q, tid_d;
   logic [TIMER_W-1:0]  tcfg_q, tcfg_d;
   logic [TIMER_W-1:0]  tval_q, tval_d;
   logic [63:0]         cnt_q;
   logic                has_int_q;

   logic                wr_ecfg, wr_estat, wr_tid, wr_tcfg, ticlr_clr;
   logic [TIMER_W-1:0]  tcfg_new;
   logic [TIMER_W-1:0]  tcfg_load;
   logic [TIMER_W-1:0]  reload_val;
   logic                timer_fire;

   assign wr_ecfg   = csr_we && (csr_num == CSR_ECFG);
   assign wr_estat  = csr_we && (csr_num == CSR_ESTAT);
   assign wr_tid    = csr_we && (csr_num == CSR_TID);
   assign wr_tcfg   = csr_we && (csr_num == CSR_TCFG);
   assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wdata[0];

   // Value TCFG takes if this cycle writes it; TVAL loads from it directly.
   assign tcfg_new   = (tcfg_q & ~csr_wmask[TIMER_W-1:0]) | (csr_wdata[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]);
   assign tcfg_load  = {tcfg_new[TIMER_W-1:2], 2'b00};
   assign reload_val = {tcfg_q[TIMER_W-1:2], 2'b00};

   // Timer next state: countdown/expiry first, then a TCFG write overrides TVAL and state.
   always_comb begin
      state_d    = state_q;
      tval_d     = tval_q;
      timer_fire = 1'b0;
      case (state_q)
         T_RUN: begin
            if (tval_q == TVAL_ONE) begin
               timer_fire = 1'b1;
               if (tcfg_q[1] && (reload_val != '0)) begin
                  tval_d = reload_val;
               end else begin
                  tval_d  = '0;
                  state_d = T_DONE;
               end
            end else if (tval_q != '0) begin
               tval_d = tval_q - TVAL_ONE;
            end
         end
         default: ;
      endcase
      if (wr_tcfg) begin
         tval_d = tcfg_load;
         if (!tcfg_new[0]) begin
            state_d = T_IDLE;
         end else if (tcfg_load != '0) begin
            state_d = T_RUN;
         end else begin
            // Enabling with a zero count expires immediately.
            state_d    = T_DONE;
            timer_fire = 1'b1;
         end
      end
   end

   // Timer state and TVAL registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= T_IDLE;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         tval_q  <= tval_d;
      end
   end

   // Next values of the writable configuration CSRs.
   always_comb begin
      lie_d  = lie_q;
      tid_d  = tid_q;
      tcfg_d = tcfg_q;
      if (wr_ecfg) begin
         lie_d = ((lie_q & ~csr_wmask[12:0]) | (csr_wdata[12:0] & csr_wmask[12:0])) & LIE_MASK;
      end
      if (wr_tid) begin
         tid_d = (tid_q & ~csr_wmask) | (csr_wdata & csr_wmask);
      end
      if (wr_tcfg) begin
         tcfg_d = tcfg_new;
      end
   end

   // Next interrupt status: sampled lines, software bits, timer bit (set beats clear).
   always_comb begin
      is_d = is_q;
      if (wr_estat) begin
         is_d[1:0] = (is_q[1:0] & ~csr_wmask[1:0]) | (csr_wdata[1:0] & csr_wmask[1:0]);
      end
      is_d[9:2] = hard_int_in;
      is_d[10]  = 1'b0;
      is_d[12]  = ipi_int_in;
      if (timer_fire) begin
         is_d[11] = 1'b1;
      end else if (ticlr_clr) begin
         is_d[11] = 1'b0;
      end
   end

   // CSR state, stable counter and the registered interrupt request.
   always_ff @(posedge clk) begin
      if (reset) begin
         lie_q     <= '0;
         is_q      <= '0;
         tid_q     <= TID_RST;
         tcfg_q    <= '0;
         cnt_q     <= '0;
         has_int_q <= 1'b0;
      end else begin
         lie_q     <= lie_d;
         is_q      <= is_d;
         tid_q     <= tid_d;
         tcfg_q    <= tcfg_d;
         cnt_q     <= cnt_q + 64'd1;
         has_int_q <= crmd_ie & (|(is_q & lie_q));
      end
   end

   // Combinational read decode for the CSR numbers owned here.
   always_comb begin
      csr_rdata = '0;
      csr_hit   = 1'b1;
      case (csr_num)
         CSR_ECFG:  csr_rdata = {19'b0, lie_q};
         CSR_ESTAT: csr_rdata = {19'b0, is_q};
         CSR_TID:   csr_rdata = tid_q;
         CSR_TCFG:  csr_rdata = 32'(tcfg_q);
         CSR_TVAL:  csr_rdata = 32'(tval_q);
         CSR_TICLR: csr_rdata = '0;
         default:   csr_hit   = 1'b0;
      endcase
   end

   assign has_int     = has_int_q;
   assign stable_cnt  = cnt_q;
   assign timer_state = state_q;

endmodule

// File: doc/csr_int_timer_ctrl.md
Name: csr_int_timer_ctrl

Overview:
- Owns the interrupt and timer CSRs: ECFG, ESTAT.IS, TID, TCFG, TVAL and TICLR.
- Runs the constant timer and a 64-bit stable counter, and samples the hardware and IPI interrupt lines.
- Drives the registered has_int request that the writeback stage turns into an interrupt exception.
- Sits beside the main CSR file; writeback routes these CSR numbers here via the shared csr_we/num/wmask/wdata bus.

Parameters:
- TIMER_W, 32, width of TVAL and of TCFG.InitVal ({InitVal,2'b00}).
- TID_RST, 32'h0, reset value of TID.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- csr_we  input  1  CSR write strobe from writeback (already qualified by ws_valid and no exception)
- csr_num  input  14  CSR number
- csr_wmask  input  32  per-bit write mask
- csr_wdata  input  32  write data
- csr_rdata  output  32  read data for csr_num (combinational); 0 if not owned
- csr_hit  output  1  csr_num is owned by this block (0x4, 0x5, 0x40, 0x41, 0x42, 0x44)
- crmd_ie  input  1  CRMD.IE from the main CSR file
- hard_int_in  input  8  hardware interrupt lines, level-sensitive
- ipi_int_in  input  1  inter-processor interrupt line, level-sensitive
- has_int  output  1  interrupt request to writeback, registered
- stable_cnt  output  64  stable counter value for rdcntvl/rdcntvh
- timer_state  output  2  FSM state, for debug and verification

Behaviour:
Reset is synchronous, active-high, on clk.
- Reset values: ECFG.LIE=0; ESTAT.IS=0; TID=TID_RST; TCFG=0; TVAL=0; stable_cnt=0; has_int=0; FSM=T_IDLE.
- Registers not named in a write below are read-only.

Register writes: new = (old & ~wmask) | (wdata & wmask).
- ECFG (0x4): LIE bits [9:0] and [12:11] are writable; bit 10 and bits [31:13] read 0.
- ESTAT (0x5): only IS[1:0] (software interrupts) are writable.
- TID (0x40): fully writable.
- TCFG (0x41): En=[0], Periodic=[1], InitVal=[TIMER_W-1:2]. Any TCFG write loads TVAL <= {new InitVal, 2'b00} in the same cycle.
- TVAL (0x42): read-only.
- TICLR (0x44): writing 1 to bit 0 with wmask[0]=1 clears IS[11]. TICLR always reads 0.

Interrupt sampling:
- IS[9:2] <= hard_int_in and IS[12] <= ipi_int_in every cycle (one-cycle sample delay).
- IS[10] always reads 0.

Timer FSM (timer_state encoding 0/1/2):
- T_IDLE: TVAL holds its value.
  - TCFG write with En=1 and loaded TVAL != 0 -> T_RUN.
  - TCFG write with En=1 and loaded TVAL == 0 -> T_DONE, IS[11] set next cycle.
- T_RUN: TVAL decrements by 1 each cycle.
  - When TVAL==1 this cycle: set IS[11].
    - Periodic=1: TVAL <= {InitVal,2'b00}, stay in T_RUN.
    - Periodic=0: TVAL <= 0, go to T_DONE.
  - TCFG write with En=0 -> T_IDLE; the current TVAL load rule still applies.
- T_DONE: TVAL holds 0.
  - TCFG write with En=1 -> reload TVAL and enter T_RUN.
  - TCFG write with En=0 -> T_IDLE.
- Wrap-around: TVAL never wraps below 0.

Simultaneous events:
- A TCFG write in the same cycle as expiry: the write wins for TVAL and state. IS[11] is still set.
- A TICLR clear in the same cycle as an IS[11] set: the set wins.
- A csr_we to ESTAT in the same cycle as an IS[11] set: IS[11] is set; the write does not touch it.

Stable counter:
- stable_cnt increments by 1 every cycle.
- Wraps from 2^64-1 to 0.

Interrupt request:
- has_int <= crmd_ie & |(IS & LIE) over bits [12:0].
- Latency: 1 cycle from an IS/LIE/crmd_ie change to has_int.
- Hardware lines therefore take 2 cycles from pin to has_int.

Test Plan:
1. Reset mid-count: TCFG=0x0000_0009 (En=1, InitVal=2 -> TVAL=8), then assert reset after 3 cycles -> TVAL=0, timer_state=0, IS=0, has_int=0 on the next edge.
2. One-shot timer: write TCFG=0x11 (En, InitVal=4 -> TVAL=16) -> TVAL counts 16..1, IS[11]=1 and timer_state=2 after 16 cycles, then TVAL holds 0. With LIE=0x800 and crmd_ie=1, has_int=1 one cycle after IS[11] is set.
3. Periodic timer: write TCFG=0x0B (En, Periodic, InitVal=2 -> TVAL=8) -> IS[11] is set every 8 cycles and TVAL reloads to 8. A TICLR write of 1 clears IS[11]; a TICLR in the same cycle as expiry leaves IS[11]=1.
4. Hardware interrupt and masking: hard_int_in=0x04, LIE=0x010, crmd_ie=1 -> IS[4]=1 after 1 cycle and has_int=1 after 2 cycles. Dropping crmd_ie -> has_int=0 next cycle.
5. Masked writes: ESTAT write wdata=0xFFFF_FFFF, wmask=0x3 -> IS[1:0]=3 with other bits unchanged. ECFG write wdata=0xFFFF_FFFF, wmask=all ones -> reads 0x0000_1BFF.
6. Read decode: csr_num=0x42 while running -> csr_hit=1 and csr_rdata equals the current TVAL. csr_num=0x0 -> csr_hit=0, csr_rdata=0. stable_cnt equals the number of cycles since reset.
